// File: rtl/bcd_scan_counter.sv
// BCD up/down counter stepped by rising edges of a divided tick, time-multiplexed onto a seven-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits above digit 0).
module bcd_scan_counter #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic                tick_q;
    logic                step;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    idx;

    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic                inc_carry;
    logic                dec_borrow;
    logic [4*DIGITS-1:0] count_nxt;
    logic                wrap_nxt;

    logic [3:0]          sel_digit;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   an_onehot;
    logic [6:0]          seg_raw;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes decode to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign step = tick_in & ~tick_q;

    // Ripple increment/decrement; carry/borrow out of the top digit is the wrap condition.
    always_comb begin
        inc_val    = count_bcd;
        dec_val    = count_bcd;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (count_bcd[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_bcd[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else if (count_bcd[4*i +: 4] > 4'd9) begin
                    dec_val[4*i +: 4] = 4'd9;
                    dec_borrow        = 1'b0;
                end else begin
                    dec_val[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_nxt = count_bcd;
        wrap_nxt  = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (step && en) begin
            if (up_down) begin
                count_nxt = inc_val;
                wrap_nxt  = inc_carry;
            end else begin
                count_nxt = dec_val;
                wrap_nxt  = dec_borrow;
            end
        end
    end

    always_comb begin
        sel_digit = 4'd0;
        an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_onehot[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                sel_digit = count_nxt[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 is blank when it and every higher digit are zero.
    always_comb begin
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (count_nxt[4*i +: 4] == 4'd0);
            if (i > 0) begin
                blank_mask[i] = hi_zero;
            end
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        seg_raw = seg7(sel_digit);
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i) && blank_mask[i]) begin
                seg_raw = 7'b0000000;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_q    <= 1'b0;
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else begin
            tick_q    <= tick_in;
            count_bcd <= count_nxt;
            wrap      <= wrap_nxt;
        end
    end

    // Scan timing free-runs independent of the counting controls.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            an  <= ACTIVE_LOW ? '1 : '0;
            seg <= ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
        end else begin
            an  <= ACTIVE_LOW ? ~an_onehot : an_onehot;
            seg <= ACTIVE_LOW ? ~seg_raw : seg_raw;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1); expected values queued by stimulus,
// checked by an independent negedge monitor. Honours LEADING_ZERO_BLANK_EN for the blanked-digit expectations.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_LZ    = SEG_BLANK;
`else
  localparam logic [6:0] SEG_LZ    = SEG_0;
`endif

  localparam int K_COUNT = 0;
  localparam int K_WRAP  = 1;
  localparam int K_AN    = 2;
  localparam int K_SEG   = 3;

  localparam time TIMEOUT = 200us;

  logic                clk_in = 1'b0;
  logic                rst = 1'b1;
  logic                tick_in = 1'b0;
  logic                en = 1'b0;
  logic                up_down = 1'b1;
  logic                clear = 1'b0;
  logic [4*DIGITS-1:0] count_bcd;
  logic                wrap;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          edge_n  = 0;

  bcd_scan_counter #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .tick_in(tick_in),
    .en(en),
    .up_down(up_down),
    .clear(clear),
    .count_bcd(count_bcd),
    .wrap(wrap),
    .seg(seg),
    .an(an)
  );

  // Clock and reference edge count since reset release (drives the scan model).
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Watchdog.
  initial begin
    #(TIMEOUT);
    n_fail++;
    $display("FAIL timeout: simulation did not finish within %0t", TIMEOUT);
    $display("[TB] %0d tests run, %0d failed -- FAIL", n_tests, n_fail);
    $finish;
  end

  // Scoreboard monitor.
  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          k;
      string       nm;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      case (k)
        K_COUNT: begin a = {16'h0, count_bcd}; nm = "count_bcd"; end
        K_WRAP:  begin a = {31'h0, wrap};      nm = "wrap";      end
        K_AN:    begin a = {28'h0, an};        nm = "an";        end
        default: begin a = {25'h0, seg};       nm = "seg";       end
      endcase
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, a, e);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] val);
    kind_q.push_back(kind);
    exp_q.push_back(val);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    cyc();
  endtask

  task automatic expect_count(input logic [15:0] c, input logic w);
    expect_val(K_COUNT, {16'h0, c});
    expect_val(K_WRAP, {31'h0, w});
  endtask

  // Direct reset-state check.
  task automatic check_reset_state();
    n_tests++;
    if (count_bcd !== 16'h0000 || wrap !== 1'b0 || an !== 4'b1111 || seg !== SEG_BLANK) begin
      n_fail++;
      $display("FAIL reset state at t=%0t: count=%h wrap=%b an=%b seg=%b",
               $time, count_bcd, wrap, an, seg);
    end
  endtask

  // Bounded wait for an to reach a value.
  task automatic wait_an(input logic [3:0] target, input int max_cyc);
    int n;
    n = 0;
    while (an !== target && n < max_cyc) begin
      cyc();
      n++;
    end
    n_tests++;
    if (an !== target) begin
      n_fail++;
      $display("FAIL wait expired at t=%0t: an=%b never reached %b within %0d cycles",
               $time, an, target, max_cyc);
    end
  endtask

  // Scan model: after edge k the displayed digit is the index held before that edge.
  task automatic scan_check(input int ncyc, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    for (int n = 0; n < ncyc; n++) begin
      int d;
      logic [3:0] oh;
      logic [6:0] s;
      cyc();
      d  = ((edge_n - 1) / SCAN_DIV) % DIGITS;
      oh = 4'b0001 << d;
      case (d)
        0:       s = s0;
        1:       s = s1;
        2:       s = s2;
        default: s = s3;
      endcase
      expect_val(K_AN, {28'h0, ~oh});
      expect_val(K_SEG, {25'h0, s});
    end
  endtask

  initial begin
    // Reset with tick toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_in = ~tick_in;
      cyc();
    end
    check_reset_state();
    expect_count(16'h0000, 1'b0);
    expect_val(K_AN, 32'h0000000F);
    expect_val(K_SEG, {25'h0, SEG_BLANK});
    rst     = 1'b0;
    tick_in = 1'b0;
    wait_an(4'b1110, 1);
    expect_val(K_AN, 32'h0000000E);
    expect_val(K_SEG, {25'h0, SEG_0});

    // Up counting across a digit carry.
    en      = 1'b1;
    up_down = 1'b1;
    for (int i = 0; i < 12; i++) pulse();
    expect_count(16'h0012, 1'b0);

    // Held tick gives exactly one step.
    tick_in = 1'b1;
    cyc();
    expect_count(16'h0013, 1'b0);
    for (int i = 0; i < 9; i++) cyc();
    expect_count(16'h0013, 1'b0);
    tick_in = 1'b0;
    cyc();

    // Plain down step.
    up_down = 1'b0;
    pulse();
    expect_count(16'h0012, 1'b0);
    up_down = 1'b1;

    // Scan sequence at 0012, more than one full rotation.
    scan_check(20, SEG_2, SEG_1, SEG_LZ, SEG_LZ);

    // Clear beats a coincident step.
    clear   = 1'b1;
    tick_in = 1'b1;
    cyc();
    expect_count(16'h0000, 1'b0);
    clear   = 1'b0;
    tick_in = 1'b0;
    cyc();
    expect_count(16'h0000, 1'b0);

    // Underflow then overflow wrap pulses.
    up_down = 1'b0;
    tick_in = 1'b1;
    cyc();
    expect_count(16'h9999, 1'b1);
    tick_in = 1'b0;
    cyc();
    expect_count(16'h9999, 1'b0);
    up_down = 1'b1;
    tick_in = 1'b1;
    cyc();
    expect_count(16'h0000, 1'b1);
    tick_in = 1'b0;
    cyc();
    expect_count(16'h0000, 1'b0);

    // Enable gating.
    for (int i = 0; i < 3; i++) pulse();
    expect_count(16'h0003, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) pulse();
    expect_count(16'h0003, 1'b0);
    en = 1'b1;

    // All-zero display: digit 0 is never blanked.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    scan_check(16, SEG_0, SEG_LZ, SEG_LZ, SEG_LZ);

    // Reset mid-scan and mid-count.
    pulse();
    expect_count(16'h0001, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    check_reset_state();
    expect_count(16'h0000, 1'b0);
    expect_val(K_AN, 32'h0000000F);
    expect_val(K_SEG, {25'h0, SEG_BLANK});
    rst = 1'b0;
    wait_an(4'b1110, 1);
    expect_val(K_AN, 32'h0000000E);

    @(negedge clk_in);
    #1;
    $display("[TB] %0d tests run, %0d failed -- %s", n_tests, n_fail, (n_fail == 0) ? "PASS" : "FAIL");
    $finish;
  end

endmodule
